dmem_responder: RTL and testbench

//  Memory-side responder for MEM-stage load/store requests: single-port word-organised data RAM behind
//  a valid/ready request channel and a valid/ready response channel. Performs RV32 LB/LH/LW/LBU/LHU
//  and SB/SH/SW with sign/zero extension and byte-lane merge; models fixed wait-state latency.
//  One outstanding request; sits between the pipelined MEM stage (requester) and backing storage.

---
 rtl/dmem_responder.sv | 199 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind valid/ready request/response channels,
// performing RV32 sub-word loads/stores with fixed wait states. Option macro: DMEM_MISALIGN_ERR_EN.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_ctrl_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    state_t                state, state_nx;
    logic [3:0]            cnt;
    logic                  enter_resp;
    logic                  accept;
    logic                  mem_we;

    logic                  lat_we;
    logic [ADDR_WIDTH+1:0] lat_addr;
    logic [31:0]           lat_wdata;
    logic [2:0]            lat_ctrl;

    logic                  a_we;
    logic [ADDR_WIDTH+1:0] a_addr;
    logic [31:0]           a_wdata;
    logic [2:0]            a_ctrl;

    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            off;
    logic [31:0]           rword;
    logic [31:0]           shifted;
    logic [31:0]           ld_data;
    logic [31:0]           st_data;
    logic [3:0]            st_be;
    logic                  illegal;
    logic                  acc_err;

    logic [31:0]           mem [DEPTH];

    logic                  unused_bits;
    assign unused_bits = ^{req_addr_i[31:ADDR_WIDTH+2], INIT_FILE == ""};

    assign req_ready_o = (state == S_IDLE);
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_nx   = state;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (WAIT_STATES == 0) begin
                        state_nx   = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_nx   = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge, so it must use the live request.
    always_comb begin
        if (state == S_IDLE) begin
            a_we    = req_we_i;
            a_addr  = req_addr_i[ADDR_WIDTH+1:0];
            a_wdata = req_wdata_i;
            a_ctrl  = req_ctrl_i;
        end else begin
            a_we    = lat_we;
            a_addr  = lat_addr;
            a_wdata = lat_wdata;
            a_ctrl  = lat_ctrl;
        end
    end

    always_comb begin
        idx     = a_addr[ADDR_WIDTH+1:2];
        illegal = a_we ? (a_ctrl[2] || (a_ctrl[1:0] == 2'b11))
                       : ((a_ctrl[1:0] == 2'b11) || (a_ctrl == 3'b110));
`ifdef DMEM_MISALIGN_ERR_EN
        acc_err = illegal
                || ((a_ctrl[1:0] == 2'b01) && a_addr[0])
                || ((a_ctrl[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
`else
        acc_err = illegal;
`endif
        off = a_addr[1:0];
        if (a_ctrl[1:0] == 2'b01) begin
            off[0] = 1'b0;
        end else if (a_ctrl[1:0] == 2'b10) begin
            off = 2'b00;
        end

        rword   = mem[idx];
        shifted = rword >> {off, 3'b000};
        case (a_ctrl)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_data = {24'b0, shifted[7:0]};
            3'b101:  ld_data = {16'b0, shifted[15:0]};
            default: ld_data = rword;
        endcase

        case (a_ctrl[1:0])
            2'b00: begin
                st_be   = 4'b0001 << off;
                st_data = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = 4'b0011 << off;
                st_data = {2{a_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = a_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_ctrl    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lat_we    <= req_we_i;
                lat_addr  <= req_addr_i[ADDR_WIDTH+1:0];
                lat_wdata <= req_wdata_i;
                lat_ctrl  <= req_ctrl_i;
                cnt       <= WS;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= acc_err;
                rsp_rdata_o <= (acc_err || a_we) ? '0 : ld_data;
            end else if ((state == S_RESP) && rsp_ready_i) begin
                rsp_valid_o <= 1'b0;
                rsp_rdata_o <= '0;
                rsp_err_o   <= 1'b0;
            end
        end
    end

    assign mem_we = enter_resp && a_we && !acc_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (st_be[b]) begin
                    mem[idx][b*8 +: 8] <= st_data[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model, random and directed traffic.
module tb_dmem_responder;

    localparam int AW     = 4;
    localparam int WS     = 2;
    localparam int NBYTES = 4 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid_i = 1'b0;
    logic        req_we_i    = 1'b0;
    logic [31:0] req_addr_i  = '0;
    logic [31:0] req_wdata_i = '0;
    logic [2:0]  req_ctrl_i  = '0;
    logic        rsp_ready_i = 1'b0;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS), .INIT_FILE("")) u_dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_ctrl_i(req_ctrl_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
    );

    logic        v1 = 1'b0, we1 = 1'b0;
    logic [31:0] a1 = '0, wd1 = '0;
    logic [2:0]  c1 = '0;
    logic        rr1 = 1'b1;
    logic        rdy1, rv1, re1;
    logic [31:0] rd1;

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid_i(v1), .req_ready_o(rdy1), .req_we_i(we1),
        .req_addr_i(a1), .req_wdata_i(wd1), .req_ctrl_i(c1),
        .rsp_valid_o(rv1), .rsp_ready_i(rr1),
        .rsp_rdata_o(rd1), .rsp_err_o(re1)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned rise;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  mb [NBYTES];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    bit          hold_low = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: byte-addressed memory, access size from funct3, result built byte by byte.
    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [2:0] ctrl, output logic [31:0] rd, output logic err);
        int unsigned size, off, base;
        logic [31:0] v;
        size = (ctrl[1:0] == 2'd0) ? 1 : (ctrl[1:0] == 2'd1) ? 2 : 4;
        base = int'(addr[AW+1:2]) * 4;
        off  = int'(addr[1:0]);
        err  = we ? (ctrl > 3'd2) : (ctrl == 3'd3 || ctrl == 3'd6 || ctrl == 3'd7);
`ifdef DMEM_MISALIGN_ERR_EN
        if (off % size != 0) err = 1'b1;
`endif
        off = off - off % size;
        rd  = '0;
        if (err) return;
        if (we) begin
            for (int unsigned i = 0; i < size; i++) mb[base + off + i] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int unsigned i = 0; i < size; i++) v[8*i +: 8] = mb[base + off + i];
            if (!ctrl[2] && size < 4 && v[8*size-1])
                for (int unsigned i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            rd = v;
        end
    endfunction

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] ctrl, input bit track);
        int unsigned n = 0;
        logic [31:0] rd;
        logic        e;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wd;
        req_ctrl_i  = ctrl;
        req_valid_i = 1'b1;
        @(negedge clk);
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            chk("accept_timeout", req_ready_o, 1);
        end else begin
            @(posedge clk);
            #1;
            if (track) begin
                model(we, addr, wd, ctrl, rd, e);
                sbq.push_back('{rdata: rd, err: e, rise: cyc + WS});
            end
        end
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while ((sbq.size() != 0 || rsp_valid_o) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sbq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        rsp_ready_i = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    logic        prev_v = 1'b0, prev_r = 1'b0, prev_e = 1'b0;
    logic [31:0] prev_d = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", rsp_valid_o, 1);
                chk("hold_rdata", rsp_rdata_o, prev_d);
                chk("hold_err", rsp_err_o, prev_e);
            end
            if (rsp_valid_o) chk("busy_req_ready", req_ready_o, 0);
            if (rsp_valid_o && !prev_v) begin
                if (sbq.size() == 0) chk("unexpected_rsp", rsp_valid_o, 0);
                else chk("latency_cycle", cyc, sbq[0].rise);
            end
            if (rsp_valid_o && rsp_ready_i && sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("rsp_rdata", rsp_rdata_o, e.rdata);
                chk("rsp_err", rsp_err_o, e.err);
            end
        end
        prev_v = rsp_valid_o;
        prev_r = rsp_ready_i;
        prev_d = rsp_rdata_o;
        prev_e = rsp_err_o;
    end

    initial begin
        int unsigned n;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_rdata", rsp_rdata_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < (1 << AW); i++) issue(1'b1, 32'(i * 4), $urandom, 3'b010, 1'b1);

        issue(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        issue(1'b1, 32'h10, 32'h0, 3'b010, 1'b1);
        issue(1'b1, 32'h13, 32'h80, 3'b000, 1'b1);
        issue(1'b0, 32'h13, 32'h0, 3'b000, 1'b1);
        issue(1'b0, 32'h13, 32'h0, 3'b100, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        issue(1'b0, 32'h11, 32'h0, 3'b001, 1'b1);
        issue(1'b0, 32'h13, 32'h0, 3'b101, 1'b1);

        // Response stall with a competing request that must not be taken.
        drain();
        hold_low = 1'b1;
        issue(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
        n = 0;
        while (!rsp_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_rsp_seen", rsp_valid_o, 1);
        req_we_i = 1'b1; req_addr_i = 32'h10; req_wdata_i = 32'h55; req_ctrl_i = 3'b010;
        req_valid_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_req_ready", req_ready_o, 0);
        end
        req_valid_i = 1'b0;
        hold_low = 1'b0;

        // Reset during WAIT drops the store.
        issue(1'b1, 32'h20, 32'hA5A5A5A5, 3'b010, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rstw_rsp_valid", rsp_valid_o, 0);
        chk("rstw_req_ready", req_ready_o, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rstw_no_rsp", rsp_valid_o, 0);
        end
        @(posedge clk);
        #1;
        issue(1'b0, 32'h20, 32'h0, 3'b010, 1'b1);

        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();

        // Zero-wait-state instance: one access every two cycles with an always-ready requester.
        v1 = 1'b1; we1 = 1'b1; a1 = 32'h8; wd1 = 32'h12345678; c1 = 3'b010;
        @(negedge clk);
        chk("ws0_ready", rdy1, 1);
        @(posedge clk);
        #1;
        we1 = 1'b0;
        @(negedge clk);
        chk("ws0_st_valid", rv1, 1);
        chk("ws0_st_err", re1, 0);
        chk("ws0_st_rdata", rd1, 0);
        chk("ws0_busy", rdy1, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ws0_idle", rdy1, 1);
        chk("ws0_gap", rv1, 0);
        @(posedge clk);
        #1;
        c1 = 3'b011;
        @(negedge clk);
        chk("ws0_ld_valid", rv1, 1);
        chk("ws0_ld_rdata", rd1, 32'h12345678);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ws0_idle2", rdy1, 1);
        @(posedge clk);
        #1;
        v1 = 1'b0;
        @(negedge clk);
        chk("ws0_ill_valid", rv1, 1);
        chk("ws0_ill_err", re1, 1);
        chk("ws0_ill_rdata", rd1, 0);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
